glb_bank_ctrl: RTL and testbench
================================

# glb_bank_ctrl

Arbitrating controller in front of one global-buffer bank memory. It shares the single-ported bank between NUM_REQ requesters, such as the processor port, stream port and config read port. Each cycle it grants one requester round-robin and registers the winning access onto the bank interface. It expands the byte strobe into a bit-select and tracks in-flight reads so each returned word is tagged to the requester that issued it.

## Interface
Parameters:
- NUM_REQ, 3, number of requesters (2..8)
- RD_LATENCY, 3, cycles from bank_ren high to valid bank_data_out

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request
- req_wr  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ×BANK_ADDR_WIDTH  byte address
- req_data  in  NUM_REQ×BANK_DATA_WIDTH  write data
- req_strb  in  NUM_REQ×BANK_STRB_WIDTH  write byte enables
- req_gnt  out  NUM_REQ  one-hot grant, same cycle as accepted request
- rd_data  out  BANK_DATA_WIDTH  read data (direct from bank_data_out)
- rd_data_valid  out  NUM_REQ  one-hot, rd_data belongs to this requester
- bank_ren, bank_wen  out  1  bank read/write enable
- bank_addr  out  BANK_ADDR_WIDTH  byte address to bank
- bank_data_in  out  BANK_DATA_WIDTH  write data to bank
- bank_data_in_bit_sel  out  BANK_DATA_WIDTH  bit write mask
- bank_data_out  in  BANK_DATA_WIDTH  bank read data

## Operation
- Arbitration is round-robin over req_valid. A priority pointer ptr holds the highest-priority index.
  - Winner: first i with req_valid[i], scanning ptr, ptr+1, … mod NUM_REQ.
  - req_gnt[winner] is combinational and is the only grant that cycle.
  - After a grant, ptr ← winner+1 mod NUM_REQ. With no request, ptr is held.
- A request is accepted only in a cycle where req_gnt is high. Requesters hold valid and payload until granted. No request is ever dropped.
- Accepted access is registered into the bank stage on the next edge:
  - bank_wen = req_wr & |req_strb.
  - bank_ren = ~req_wr.
  - bank_addr, bank_data_in pass through.
  - bank_data_in_bit_sel: byte b of the mask = {8{req_strb[b]}}.
- Write with req_strb == 0: granted, rotates ptr, but no bank_wen. Its bank stage is idle.
- bank_ren and bank_wen are never high together. In cycles without an accepted access, both enables are 0 and addr/data/bit_sel hold their last values.
- Read tagging uses a RD_LATENCY-deep shift chain of {valid, id}. It is loaded from the bank stage when bank_ren=1.
  - rd_data_valid[id] = chain tail valid.
  - rd_data = bank_data_out unconditionally.
- Back-to-back reads: one per cycle sustained, with no bubbles and returns in order.
- Write data is visible to a read granted one or more cycles later. Same-address write→read ordering follows grant order.

## Timing
- Grant on cycle t → bank_ren/bank_wen high in cycle t+1.
- Read granted at t → rd_data_valid high in cycle t+1+RD_LATENCY (t+4 at default), for exactly one cycle.
- Reset values (reset_n low): req_gnt combinational but ptr=0; bank_ren=0, bank_wen=0, bank_addr=0, bank_data_in=0, bank_data_in_bit_sel=0, rd_data_valid=0.
- Reset mid-operation: the tag chain is cleared, in-flight reads are discarded with no rd_data_valid, and ptr returns to 0.
- First edge after reset_n deasserts behaves as a normal arbitration cycle.

## Structure
- global_buffer_param: BANK_STRB_WIDTH = BANK_DATA_WIDTH/8, with BANK_ADDR_WIDTH and BANK_DATA_WIDTH as existing.
- global_buffer_pkg: typedef glb_bank_req_t {wr, addr, data, strb} and typedef rd_tag_t {valid, id[$clog2(NUM_REQ)]}.
- One sub-module: glb_rr_arbiter (parameter NUM_REQ; ports req, gnt, ptr register inside, async active-low reset).
- glb_bank_ctrl instantiates the arbiter, the bank-stage registers, the strobe expander and the tag chain.

## Test plan
- All three requesters assert reads continuously from reset → grants cycle 0,1,2,0,…; each rd_data_valid one-hot returns 4 cycles after its grant with the matching word.
- Req1 writes addr 0x40, data 0x1122334455667788, strb 0x0F; then req0 reads 0x40 → bank_data_in_bit_sel = 0x00000000FFFFFFFF; the read returns new low 32 bits and the old high 32 bits.
- Req2 write with strb 0x00 → req_gnt[2]=1, bank_wen stays 0, ptr advances to 0.
- Only req1 requests for 5 cycles, then req0 and req1 both request → req1 granted every cycle; at the contention, req0 wins (ptr=2 wraps to 0).
- Issue 3 reads, pull reset_n low 2 cycles after the first grant → no rd_data_valid appears afterward; all bank outputs 0 during reset.
- Req0 holds a request while denied 2 cycles → payload unchanged, granted on the third cycle, single bank access issued.

Source files
------------

// File: rtl/glb_bank_ctrl_pkg.sv
// global_buffer_param / global_buffer_pkg: bank geometry, request and read-tag types
package global_buffer_param;
    localparam int BANK_ADDR_WIDTH = 17;
    localparam int BANK_DATA_WIDTH = 64;
    localparam int BANK_STRB_WIDTH = BANK_DATA_WIDTH / 8;
endpackage

package global_buffer_pkg;
    import global_buffer_param::*;
    // Sized for the largest supported NUM_REQ (8) so the tag type is parameter-independent
    localparam int MAX_ID_WIDTH = 3;

    typedef struct packed {
        logic                       wr;
        logic [BANK_ADDR_WIDTH-1:0] addr;
        logic [BANK_DATA_WIDTH-1:0] data;
        logic [BANK_STRB_WIDTH-1:0] strb;
    } glb_bank_req_t;

    typedef struct packed {
        logic                    valid;
        logic [MAX_ID_WIDTH-1:0] id;
    } rd_tag_t;

    function automatic logic [BANK_DATA_WIDTH-1:0] strb_to_bit_sel(input logic [BANK_STRB_WIDTH-1:0] strb);
        logic [BANK_DATA_WIDTH-1:0] bit_sel;
        for (int b = 0; b < BANK_STRB_WIDTH; b++)
            bit_sel[b*8 +: 8] = {8{strb[b]}};
        return bit_sel;
    endfunction
endpackage

// File: rtl/glb_bank_ctrl_rr_arbiter.sv
// glb_rr_arbiter: round-robin arbiter with combinational one-hot grant and rotating priority pointer
module glb_rr_arbiter #(
    parameter int NUM_REQ = 3,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IW-1:0]      win
);
    logic [IW-1:0] ptr;

    // Scan from lowest priority to highest so the highest-priority hit is written last
    always_comb begin
        int j;
        gnt = '0;
        win = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % NUM_REQ;
            if (req[j]) begin
                win = IW'(j);
                gnt = '0;
                gnt[win] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            ptr <= '0;
        else if (|req)
            ptr <= (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    end
endmodule

// File: rtl/glb_bank_ctrl.sv
// glb_bank_ctrl: round-robin shares one global-buffer bank between requesters and tags read returns
module glb_bank_ctrl
    import global_buffer_param::*;
    import global_buffer_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int RD_LATENCY = 3
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [NUM_REQ-1:0]                 req_wr,
    input  logic [NUM_REQ*BANK_ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*BANK_DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ*BANK_STRB_WIDTH-1:0] req_strb,
    output logic [NUM_REQ-1:0]                 req_gnt,
    output logic [BANK_DATA_WIDTH-1:0]         rd_data,
    output logic [NUM_REQ-1:0]                 rd_data_valid,
    output logic                               bank_ren,
    output logic                               bank_wen,
    output logic [BANK_ADDR_WIDTH-1:0]         bank_addr,
    output logic [BANK_DATA_WIDTH-1:0]         bank_data_in,
    output logic [BANK_DATA_WIDTH-1:0]         bank_data_in_bit_sel,
    input  logic [BANK_DATA_WIDTH-1:0]         bank_data_out
);
    localparam int IW = $clog2(NUM_REQ);

    logic [IW-1:0] win;
    logic [IW-1:0] bank_id;
    glb_bank_req_t sel;
    rd_tag_t       chain [RD_LATENCY];

    glb_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req_valid),
        .gnt     (req_gnt),
        .win     (win)
    );

    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (req_gnt[i])
                sel = '{wr:   req_wr[i],
                        addr: req_addr[i*BANK_ADDR_WIDTH +: BANK_ADDR_WIDTH],
                        data: req_data[i*BANK_DATA_WIDTH +: BANK_DATA_WIDTH],
                        strb: req_strb[i*BANK_STRB_WIDTH +: BANK_STRB_WIDTH]};
    end

    // Payload registers hold between accesses; only the enables return to 0
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bank_ren             <= 1'b0;
            bank_wen             <= 1'b0;
            bank_addr            <= '0;
            bank_data_in         <= '0;
            bank_data_in_bit_sel <= '0;
            bank_id              <= '0;
        end else begin
            bank_ren <= (|req_gnt) & ~sel.wr;
            bank_wen <= (|req_gnt) & sel.wr & (|sel.strb);
            if (|req_gnt) begin
                bank_addr            <= sel.addr;
                bank_data_in         <= sel.data;
                bank_data_in_bit_sel <= strb_to_bit_sel(sel.strb);
                bank_id              <= win;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < RD_LATENCY; k++)
                chain[k] <= '0;
        end else begin
            chain[0] <= '{valid: bank_ren, id: MAX_ID_WIDTH'(bank_id)};
            for (int k = 1; k < RD_LATENCY; k++)
                chain[k] <= chain[k-1];
        end
    end

    assign rd_data       = bank_data_out;
    assign rd_data_valid = chain[RD_LATENCY-1].valid ? NUM_REQ'(1) << chain[RD_LATENCY-1].id : '0;
endmodule

// File: tb/tb_glb_bank_ctrl.sv
// tb_glb_bank_ctrl: directed scoreboard bench with a 3-cycle-latency bank model
module tb_glb_bank_ctrl;
    import global_buffer_param::*;

    localparam int N  = 3;
    localparam int AW = BANK_ADDR_WIDTH;
    localparam int DW = BANK_DATA_WIDTH;
    localparam int SW = BANK_STRB_WIDTH;

    logic clk, reset_n;
    logic [N-1:0]    req_valid, req_wr, req_gnt, rd_data_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic [N*SW-1:0] req_strb;
    logic [DW-1:0]   rd_data, bank_data_in, bank_data_in_bit_sel, bank_data_out;
    logic [AW-1:0]   bank_addr;
    logic            bank_ren, bank_wen;

    glb_bank_ctrl #(.NUM_REQ(N), .RD_LATENCY(3)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr),
        .req_data(req_data), .req_strb(req_strb), .req_gnt(req_gnt),
        .rd_data(rd_data), .rd_data_valid(rd_data_valid),
        .bank_ren(bank_ren), .bank_wen(bank_wen), .bank_addr(bank_addr),
        .bank_data_in(bank_data_in), .bank_data_in_bit_sel(bank_data_in_bit_sel),
        .bank_data_out(bank_data_out)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Bank memory model: read sampled when bank_ren is high, presented 3 cycles later
    logic [DW-1:0] mem [64];
    logic [DW-1:0] p0, p1, p2;
    initial for (int w = 0; w < 64; w++) mem[w] = {32'hCAFE0000 | w, 32'hBEEF0000 | w};
    always @(posedge clk) begin
        if (bank_wen)
            mem[bank_addr[8:3]] <= (mem[bank_addr[8:3]] & ~bank_data_in_bit_sel) | (bank_data_in & bank_data_in_bit_sel);
        p0 <= mem[bank_addr[8:3]];
        p1 <= p0;
        p2 <= p1;
    end
    assign bank_data_out = p2;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int id; logic [DW-1:0] data; int cyc; } exp_t;
    exp_t q[$];
    logic [DW-1:0] exp_rd [N];
    int errors = 0, checks = 0;

    task automatic chk(input string nm, input logic [DW-1:0] a, input logic [DW-1:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, a, e, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rd_data_valid != 0) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got rd_data_valid %b expected none (cycle %0d)", rd_data_valid, cyc);
            end else begin
                exp_t e;
                logic [N-1:0] oh;
                e = q.pop_front();
                oh = N'(1) << e.id;
                chk("rd_valid", DW'(rd_data_valid), DW'(oh));
                chk("rd_data", rd_data, e.data);
                chk("rd_cycle", DW'(cyc), DW'(e.cyc));
            end
        end
    end

    task automatic set_req(input int i, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [SW-1:0] s, input logic [DW-1:0] er);
        req_valid[i] = 1'b1;
        req_wr[i] = w;
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
        req_strb[i*SW +: SW] = s;
        exp_rd[i] = er;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gchk(input logic [N-1:0] e, input string nm);
        @(negedge clk);
        chk(nm, DW'(req_gnt), DW'(e));
        for (int i = 0; i < N; i++)
            if (req_gnt[i] && req_valid[i] && !req_wr[i])
                q.push_back('{i, exp_rd[i], cyc + 4});
    endtask

    function automatic logic [DW-1:0] pat(input int w);
        return {32'hCAFE0000 | w, 32'hBEEF0000 | w};
    endfunction

    task automatic chk_idle_zero(input string nm);
        chk({nm, "_ren"}, DW'(bank_ren), 0);
        chk({nm, "_wen"}, DW'(bank_wen), 0);
        chk({nm, "_addr"}, DW'(bank_addr), 0);
        chk({nm, "_din"}, bank_data_in, 0);
        chk({nm, "_bitsel"}, bank_data_in_bit_sel, 0);
        chk({nm, "_rdv"}, DW'(rd_data_valid), 0);
    endtask

    initial begin
        reset_n = 0;
        req_valid = '0; req_wr = '0; req_addr = '0; req_data = '0; req_strb = '0;
        for (int i = 0; i < N; i++) exp_rd[i] = '0;
        repeat (2) tick();
        for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(i * 8), '0, '0, pat(i));
        @(negedge clk);
        chk_idle_zero("rst");
        chk("rst_gnt", DW'(req_gnt), DW'(3'b001));
        tick();
        reset_n = 1;

        // All three read continuously: grants rotate 0,1,2,...
        for (int n = 0; n < 9; n++) begin
            gchk(N'(1) << (n % 3), "rr_gnt");
            if (n == 2) begin
                chk("rr_bank_ren", DW'(bank_ren), 1);
                chk("rr_bank_addr", DW'(bank_addr), 64'h08);
            end
            tick();
        end
        req_valid = '0;

        // Partial-strobe write then read of the same word
        set_req(1, 1'b1, 17'h40, 64'h1122334455667788, 8'h0F, '0);
        gchk(3'b010, "wr_gnt");
        tick();
        req_valid[1] = 1'b0;
        set_req(0, 1'b0, 17'h40, '0, 8'h00, {32'hCAFE0008, 32'h55667788});
        gchk(3'b001, "rd_after_wr_gnt");
        chk("wr_wen", DW'(bank_wen), 1);
        chk("wr_ren", DW'(bank_ren), 0);
        chk("wr_bitsel", bank_data_in_bit_sel, 64'h00000000FFFFFFFF);
        chk("wr_addr", DW'(bank_addr), 64'h40);
        chk("wr_din", bank_data_in, 64'h1122334455667788);
        tick();
        req_valid[0] = 1'b0;

        // Zero-strobe write: granted, rotates ptr, no bank access
        set_req(2, 1'b1, 17'h18, 64'hDEADBEEFDEADBEEF, 8'h00, '0);
        gchk(3'b100, "zstrb_gnt");
        chk("rd_ren", DW'(bank_ren), 1);
        chk("rd_wen", DW'(bank_wen), 0);
        tick();
        req_valid[2] = 1'b0;
        set_req(0, 1'b0, 17'h10, '0, '0, pat(2));
        set_req(1, 1'b0, 17'h18, '0, '0, pat(3));
        gchk(3'b001, "ptr_after_zstrb");
        chk("zstrb_wen", DW'(bank_wen), 0);
        chk("zstrb_ren", DW'(bank_ren), 0);
        tick();
        req_valid[0] = 1'b0;

        // Lone requester keeps winning, then ptr wraps to 0 under contention
        for (int n = 0; n < 5; n++) begin
            gchk(3'b010, "solo_gnt");
            tick();
        end
        set_req(0, 1'b0, 17'h20, '0, '0, pat(4));
        gchk(3'b001, "wrap_gnt");
        tick();
        req_valid[0] = 1'b0;
        gchk(3'b010, "after_wrap_gnt");
        tick();
        req_valid[1] = 1'b0;
        set_req(0, 1'b0, 17'h40, '0, '0, {32'hCAFE0008, 32'h55667788});
        gchk(3'b001, "reread_gnt");
        tick();

        // Requester 0 denied twice while holding its payload, then served once
        set_req(0, 1'b0, 17'h20, '0, '0, pat(4));
        set_req(1, 1'b0, 17'h28, '0, '0, pat(5));
        set_req(2, 1'b0, 17'h30, '0, '0, pat(6));
        gchk(3'b010, "hold_gnt1");
        tick();
        req_valid[1] = 1'b0;
        gchk(3'b100, "hold_gnt2");
        tick();
        req_valid[2] = 1'b0;
        gchk(3'b001, "hold_gnt3");
        tick();
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("hold_ren", DW'(bank_ren), 1);
        chk("hold_addr", DW'(bank_addr), 64'h20);
        tick();
        @(negedge clk);
        chk("hold_single", DW'(bank_ren), 0);
        tick();

        // Reset with reads in flight: nothing may return
        for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(i * 8), '0, '0, pat(i));
        gchk(3'b010, "flt_gnt1");
        tick();
        gchk(3'b100, "flt_gnt2");
        tick();
        gchk(3'b001, "flt_gnt3");
        #1;
        reset_n = 0;
        req_valid = '0;
        q.delete();
        @(negedge clk);
        chk_idle_zero("mid_rst");
        tick();
        tick();
        reset_n = 1;
        repeat (6) tick();
        req_valid = '1;
        gchk(3'b001, "ptr_after_rst");
        tick();
        req_valid = '0;
        repeat (8) tick();
        chk("sb_drained", DW'(q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
